// File: rtl/alu_exec_unit.sv
// ALU execution stage with Start/Ready/Done handshake toward the datapath sequencer.
// Define ALU_BARREL_SHIFT_EN for single-cycle SLL/SRA; otherwise shifts run 1 bit per cycle.
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Invalid
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  logic [1:0]         state;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   op_res;
  logic               op_ovf;
  logic               op_valid;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = B[SHAMT_W-1:0];
  assign sum   = A + B;
  assign diff  = A - B;
  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

  always_comb begin
    op_res   = '0;
    op_ovf   = 1'b0;
    op_valid = 1'b1;
    case (ALUCtrl)
      OP_AND: op_res = A & B;
      OP_OR:  op_res = A | B;
      OP_XOR: op_res = A ^ B;
      OP_ADD: begin
        op_res = sum;
        op_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: op_res[0] = ($signed(A) < $signed(B));
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: op_res = A << shamt;
      OP_SRA: op_res = $unsigned($signed(A) >>> shamt);
`else
      // Zero-distance shifts finish immediately with A; longer ones go to SHIFT.
      OP_SLL: op_res = A;
      OP_SRA: op_res = A;
`endif
      default: op_valid = 1'b0;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   next_acc;
  logic [SHAMT_W-1:0] count;
  logic               sra_op;
  logic               start_shift;

  assign start_shift = ((ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRA)) && (shamt != '0);
  assign next_acc    = sra_op ? {acc[WIDTH-1], acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      Invalid  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      acc      <= '0;
      count    <= '0;
      sra_op   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Invalid <= ~op_valid;
`ifndef ALU_BARREL_SHIFT_EN
            if (start_shift) begin
              acc    <= A;
              count  <= shamt;
              sra_op <= (ALUCtrl == OP_SRA);
              state  <= SHIFT;
            end else
`endif
            begin
              Result   <= op_res;
              Zero     <= (op_res == '0);
              Overflow <= op_ovf;
              state    <= DONE;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          acc   <= next_acc;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            Result   <= next_acc;
            Zero     <= (next_acc == '0);
            Overflow <= 1'b0;
            state    <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors plus randomized traffic
// against a behavioural model that derives results and latency from signed integer arithmetic.
module tb_alu_exec_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  ALUCtrl = 4'h0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic        Ready, Done, Zero, Overflow, Invalid;
  logic [15:0] Result;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Outstanding transaction and the architecturally held output values.
  bit          pend = 1'b0;
  bit          skip = 1'b1;
  int          acc_cyc = 0;
  int          done_at = 0;
  logic [15:0] p_res = 16'h0, h_res = 16'h0;
  logic        p_ovf = 1'b0, p_inv = 1'b0, h_ovf = 1'b0, h_inv = 1'b0;

  logic [3:0] codes [0:7] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'hC, 4'h1, 4'h6, 4'h7};

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .A(A), .B(B), .Ready(Ready), .Done(Done), .Result(Result),
    .Zero(Zero), .Overflow(Overflow), .Invalid(Invalid)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chkw(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: signed integer arithmetic, overflow as range violation, SRA as floor division.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ov, output logic inv,
                                output int lat);
    int sa, sb, t, k;
    sa = $signed(a);
    sb = $signed(b);
    k  = int'(b[3:0]);
    t  = 0; ov = 1'b0; inv = 1'b0; lat = 1;
    case (op)
      4'b0000: t = int'(a & b);
      4'b0010: t = int'(a | b);
      4'b0011: t = int'(a ^ b);
      4'b0100: begin t = sa + sb; ov = (t > 32767) || (t < -32768); end
      4'b1100: begin t = sa - sb; ov = (t > 32767) || (t < -32768); end
      4'b0001: t = (sa < sb) ? 1 : 0;
      4'b0110, 4'b0111: begin
        if (op == 4'b0110) t = int'(a) * (1 << k);
        else               t = sa >>> k;
`ifndef ALU_BARREL_SHIFT_EN
        if (k > 0) lat = k + 1;
`endif
      end
      default: inv = 1'b1;
    endcase
    r = t[15:0];
  endfunction

  task automatic pin(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] er, input logic eo, input logic ei, input int el);
    logic [15:0] r; logic o, i; int l;
    model(op, a, b, r, o, i, l);
    chkw({nm, "_res"}, r, er);
    chkb({nm, "_ovf"}, o, eo);
    chkb({nm, "_inv"}, i, ei);
    chkw({nm, "_lat"}, 16'(l), 16'(el));
  endtask

  task automatic check_vals();
    chkw("result", Result, h_res);
    chkb("zero", Zero, h_res == 16'h0);
    chkb("overflow", Overflow, h_ovf);
    chkb("invalid", Invalid, h_inv);
  endtask

  // Single compare process, sampled on the falling edge.
  always @(negedge Clock) begin
    if (skip) begin
      chkb("done_during_reset", Done, 1'b0);
    end else if (pend && cyc == done_at) begin
      chkb("ready_at_done", Ready, 1'b0);
      chkb("done_pulse", Done, 1'b1);
      h_res = p_res; h_ovf = p_ovf; h_inv = p_inv;
      pend  = 1'b0;
      check_vals();
    end else if (pend && cyc >= acc_cyc && cyc < done_at) begin
      chkb("ready_busy", Ready, 1'b0);
      chkb("done_early", Done, 1'b0);
    end else begin
      chkb("ready_idle", Ready, 1'b1);
      chkb("done_idle", Done, 1'b0);
      check_vals();
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (pend && t < 60) begin tick(); t++; end
    chkb("idle_timeout", pend, 1'b0);
    pend = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int lat;
    wait_idle();
    model(op, a, b, p_res, p_ovf, p_inv, lat);
    ALUCtrl = op; A = a; B = b; Start = 1'b1;
    acc_cyc = cyc + 1;
    done_at = cyc + lat;
    pend    = 1'b1;
    tick();
    Start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); ALUCtrl = 4'($urandom);
  endtask

  // Start pulse while busy (SHIFT or DONE); must be dropped.
  task automatic poke();
    Start = 1'b1; A = 16'($urandom); B = 16'($urandom); ALUCtrl = codes[$urandom_range(0, 7)];
    tick();
    Start = 1'b0;
  endtask

  task automatic do_reset();
    skip = 1'b1; Reset = 1'b1; pend = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    h_res = 16'h0; h_ovf = 1'b0; h_inv = 1'b0;
    skip = 1'b0;
  endtask

  function automatic logic [15:0] pickv();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int t;
    logic [3:0] op;
    pin("pin_add", 4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1);
    pin("pin_sub", 4'b1100, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1);
    pin("pin_slt", 4'b0001, 16'hFFFE, 16'h0001, 16'h0001, 1'b0, 1'b0, 1);
`ifdef ALU_BARREL_SHIFT_EN
    pin("pin_sra", 4'b0111, 16'h8010, 16'h0004, 16'hF801, 1'b0, 1'b0, 1);
`else
    pin("pin_sra", 4'b0111, 16'h8010, 16'h0004, 16'hF801, 1'b0, 1'b0, 5);
`endif
    pin("pin_sll0", 4'b0110, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1);
    pin("pin_and", 4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1);
    pin("pin_inv", 4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1);

    repeat (2) tick();
    Reset = 1'b0;
    skip  = 1'b0;
    tick();

    issue(4'b0100, 16'h7FFF, 16'h0001);
    issue(4'b1100, 16'h1234, 16'h1234);
    issue(4'b0001, 16'hFFFE, 16'h0001);
    issue(4'b0111, 16'h8010, 16'h0004);
    issue(4'b0110, 16'h0001, 16'h0000);
    issue(4'b0110, 16'h0001, 16'h000F);
    poke();
    issue(4'b1111, 16'hAAAA, 16'h5555);
    issue(4'b0000, 16'hF0F0, 16'h0FF0);

    issue(4'b0100, 16'($urandom), 16'($urandom));
    poke();
    issue(4'b0111, 16'($urandom), 16'h0003);
    t = 0;
    while (cyc < done_at && t < 40) begin tick(); t++; end
    poke();

    issue(4'b0110, 16'h00FF, 16'h0009);
    repeat (2) tick();
    do_reset();

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
      issue(op, pickv(), pickv());
      if ($urandom_range(0, 3) == 0) poke();
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    wait_idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
